// File: rtl/idli_pkg.sv
// Shared types and default geometry for the idli core control path.
package idli_pkg;

  localparam int SLICE_W    = 4;
  localparam int DATA_W     = 16;
  localparam int NUM_SLICES = DATA_W / SLICE_W;
  localparam int CTR_W      = $clog2(NUM_SLICES);

  typedef logic [CTR_W-1:0] ctr_t;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_STALL
  } ctrl_state_t;

endpackage

// File: rtl/idli_ctrl_init_m.sv
// INIT hold-off: counts down a fixed number of cycles after reset and
// qualifies the result with memory readiness.
module idli_ctrl_init_m #(
  parameter int INIT_CYCLES = 16
) (
  input  logic i_init_gck,
  input  logic i_init_rst,
  input  logic i_init_mem_rdy,
  output logic o_init_done
);

  localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  logic [IW-1:0] init_q, init_d;

  // Saturates at zero so a late mem_rdy is still honoured.
  always_comb begin
    init_d = init_q;
    if (init_q != '0) init_d = init_q - 1'b1;
  end

  always_ff @(posedge i_init_gck) begin
    if (i_init_rst) init_q <= IW'(INIT_CYCLES - 1);
    else            init_q <= init_d;
  end

  assign o_init_done = (init_q == '0) && i_init_mem_rdy;

endmodule

// File: rtl/idli_ctrl_m.sv
// Slice sequencer for the nibble-serial idli core: reset hold-off,
// instruction-aligned stall and redirect.
module idli_ctrl_m #(
  parameter int SLICE_W     = idli_pkg::SLICE_W,
  parameter int DATA_W      = idli_pkg::DATA_W,
  parameter int INIT_CYCLES = 16,
  localparam int NUM_SLICES = DATA_W / SLICE_W,
  localparam int CTR_W      = $clog2(NUM_SLICES)
) (
  input  logic             i_ctrl_gck,
  input  logic             i_ctrl_rst,
  input  logic             i_ctrl_mem_rdy,
  input  logic             i_ctrl_stall,
  input  logic             i_ctrl_redirect,
  output logic [CTR_W-1:0] o_ctrl_ctr,
  output logic             o_ctrl_first,
  output logic             o_ctrl_last,
  output logic             o_ctrl_run,
  output logic             o_ctrl_redirect
);

  import idli_pkg::*;

  localparam logic [CTR_W-1:0] LAST = CTR_W'(NUM_SLICES - 1);

  ctrl_state_t      state_q, state_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic             pend_q, pend_d;
  logic             act_q, act_d;
  logic             init_done;
  logic             boundary;

  idli_ctrl_init_m #(.INIT_CYCLES(INIT_CYCLES)) u_init (
    .i_init_gck    (i_ctrl_gck),
    .i_init_rst    (i_ctrl_rst),
    .i_init_mem_rdy(i_ctrl_mem_rdy),
    .o_init_done   (init_done)
  );

  // boundary marks every edge that lands on slice 0 of a running instruction.
  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    boundary = 1'b0;
    case (state_q)
      ST_INIT: begin
        ctr_d = '0;
        if (init_done) begin
          state_d  = ST_RUN;
          boundary = 1'b1;
        end
      end
      ST_RUN: begin
        if (ctr_q == LAST) begin
          ctr_d = '0;
          if (i_ctrl_stall) state_d  = ST_STALL;
          else              boundary = 1'b1;
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end
      ST_STALL: begin
        ctr_d = '0;
        if (!i_ctrl_stall) begin
          state_d  = ST_RUN;
          boundary = 1'b1;
        end
      end
      default: begin
        state_d = ST_INIT;
        ctr_d   = '0;
      end
    endcase
  end

  // A request seen on the boundary edge itself folds straight into the
  // next instruction so a last-slice pulse still hits instruction k+1.
  always_comb begin
    pend_d = pend_q | i_ctrl_redirect;
    act_d  = act_q;
    if (boundary) begin
      act_d  = pend_q | i_ctrl_redirect;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge i_ctrl_gck) begin
    if (i_ctrl_rst) begin
      state_q <= ST_INIT;
      ctr_q   <= '0;
      pend_q  <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
    end
  end

  assign o_ctrl_run      = (state_q == ST_RUN);
  assign o_ctrl_ctr      = ctr_q;
  assign o_ctrl_first    = o_ctrl_run && (ctr_q == '0);
  assign o_ctrl_last     = o_ctrl_run && (ctr_q == LAST);
  assign o_ctrl_redirect = o_ctrl_run && act_q;

endmodule

// File: tb/tb_idli_ctrl_m.sv
// Directed bench for idli_ctrl_m: default 4-slice instance plus a 3-slice one.
module tb_idli_ctrl_m;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rdy0, stall0, redir0;
  logic [1:0] ctr0;
  logic       first0, last0, run0, red0;

  logic       rst1, rdy1, stall1, redir1;
  logic [1:0] ctr1;
  logic       first1, last1, run1, red1;

  int ncmp = 0;
  int nerr = 0;

  idli_ctrl_m u_dut0 (
    .i_ctrl_gck     (clk),
    .i_ctrl_rst     (rst0),
    .i_ctrl_mem_rdy (rdy0),
    .i_ctrl_stall   (stall0),
    .i_ctrl_redirect(redir0),
    .o_ctrl_ctr     (ctr0),
    .o_ctrl_first   (first0),
    .o_ctrl_last    (last0),
    .o_ctrl_run     (run0),
    .o_ctrl_redirect(red0)
  );

  idli_ctrl_m #(.SLICE_W(4), .DATA_W(12), .INIT_CYCLES(4)) u_dut1 (
    .i_ctrl_gck     (clk),
    .i_ctrl_rst     (rst1),
    .i_ctrl_mem_rdy (rdy1),
    .i_ctrl_stall   (stall1),
    .i_ctrl_redirect(redir1),
    .o_ctrl_ctr     (ctr1),
    .o_ctrl_first   (first1),
    .o_ctrl_last    (last1),
    .o_ctrl_run     (run1),
    .o_ctrl_redirect(red1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One 4-slice instruction on dut0; pm[i] pulses redirect during slice i.
  task automatic inst(input string tag, input logic [3:0] pm, input logic er);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_ctr"},   32'(ctr0), 32'(i));
      chk({tag, "_run"},   32'(run0), 32'd1);
      chk({tag, "_first"}, 32'(first0), 32'(i == 0));
      chk({tag, "_last"},  32'(last0), 32'(i == 3));
      chk({tag, "_redir"}, 32'(red0), 32'(er));
      redir0 = pm[i];
      step();
      redir0 = 1'b0;
    end
  endtask

  initial begin
    rst0 = 1'b1; rdy0 = 1'b1; stall0 = 1'b0; redir0 = 1'b0;
    rst1 = 1'b1; rdy1 = 1'b1; stall1 = 1'b0; redir1 = 1'b0;
    repeat (3) step();
    chk("rst_ctr",   32'(ctr0), 32'd0);
    chk("rst_first", 32'(first0), 32'd0);
    chk("rst_last",  32'(last0), 32'd0);
    chk("rst_run",   32'(run0), 32'd0);
    chk("rst_redir", 32'(red0), 32'd0);

    // Hold-off: run appears on the 16th edge after the last reset edge.
    rst0 = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      step();
      chk("init_run", 32'(run0), 32'd0);
    end
    step();
    chk("start_run",   32'(run0), 32'd1);
    chk("start_ctr",   32'(ctr0), 32'd0);
    chk("start_first", 32'(first0), 32'd1);
    chk("start_last",  32'(last0), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("seq_ctr",   32'(ctr0), 32'(i % 4));
      chk("seq_first", 32'(first0), 32'((i % 4) == 0));
      chk("seq_last",  32'(last0), 32'((i % 4) == 3));
      chk("seq_run",   32'(run0), 32'd1);
    end

    // Memory not ready until cycle 40.
    rst0 = 1'b1; rdy0 = 1'b0;
    step();
    chk("rst2_run", 32'(run0), 32'd0);
    chk("rst2_ctr", 32'(ctr0), 32'd0);
    rst0 = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      step();
      chk("rdy_low_run", 32'(run0), 32'd0);
    end
    rdy0 = 1'b1;
    step();
    chk("rdy_run",   32'(run0), 32'd1);
    chk("rdy_ctr",   32'(ctr0), 32'd0);
    chk("rdy_first", 32'(first0), 32'd1);

    // Stall raised mid-instruction: slices finish, then 3 stalled cycles.
    step();
    chk("stl_ctr1", 32'(ctr0), 32'd1);
    stall0 = 1'b1;
    step();
    chk("stl_ctr2", 32'(ctr0), 32'd2);
    chk("stl_run2", 32'(run0), 32'd1);
    step();
    chk("stl_ctr3", 32'(ctr0), 32'd3);
    chk("stl_last", 32'(last0), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stl_run",   32'(run0), 32'd0);
      chk("stl_ctr",   32'(ctr0), 32'd0);
      chk("stl_first", 32'(first0), 32'd0);
    end
    stall0 = 1'b0;
    step();
    chk("unstl_run",   32'(run0), 32'd1);
    chk("unstl_ctr",   32'(ctr0), 32'd0);
    chk("unstl_first", 32'(first0), 32'd1);

    // Redirect windows.
    inst("r1a", 4'b0100, 1'b0);
    inst("r1b", 4'b0000, 1'b1);
    inst("r1c", 4'b0000, 1'b0);
    inst("r2a", 4'b0101, 1'b0);
    inst("r2b", 4'b0000, 1'b1);
    inst("r2c", 4'b0000, 1'b0);
    inst("r3a", 4'b1000, 1'b0);
    inst("r3b", 4'b0001, 1'b1);
    inst("r3c", 4'b0000, 1'b1);
    inst("r3d", 4'b0000, 1'b0);

    // Three-slice instance.
    rst1 = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("n3_init_run", 32'(run1), 32'd0);
    end
    step();
    chk("n3_run",  32'(run1), 32'd1);
    chk("n3_ctr0", 32'(ctr1), 32'd0);
    step();
    chk("n3_ctr1", 32'(ctr1), 32'd1);
    step();
    chk("n3_ctr2",  32'(ctr1), 32'd2);
    chk("n3_last2", 32'(last1), 32'd1);
    step();
    chk("n3_wrap",  32'(ctr1), 32'd0);
    chk("n3_first", 32'(first1), 32'd1);
    step();
    chk("n3_ctr1b", 32'(ctr1), 32'd1);
    redir1 = 1'b1; stall1 = 1'b1;
    step();
    redir1 = 1'b0;
    chk("n3_last", 32'(last1), 32'd1);
    step();
    chk("n3_stl_run", 32'(run1), 32'd0);
    chk("n3_stl_ctr", 32'(ctr1), 32'd0);
    step();
    chk("n3_stl_run2", 32'(run1), 32'd0);
    rst1 = 1'b1; redir1 = 1'b1;
    step();
    rst1 = 1'b0; redir1 = 1'b0; stall1 = 1'b0;
    chk("n3_rst_run",   32'(run1), 32'd0);
    chk("n3_rst_ctr",   32'(ctr1), 32'd0);
    chk("n3_rst_first", 32'(first1), 32'd0);
    chk("n3_rst_last",  32'(last1), 32'd0);
    chk("n3_rst_redir", 32'(red1), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("n3_re_init", 32'(run1), 32'd0);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      chk("n3_re_run",   32'(run1), 32'd1);
      chk("n3_re_ctr",   32'(ctr1), 32'(i % 3));
      chk("n3_re_redir", 32'(red1), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
